jt12_slot_sched: RTL and testbench
==================================

# jt12_slot_sched

Operator-slot scheduler for the FM modulation datapath. Generates the 24-slot operator sequence (6 channels × 4 operators, time order S1, S3, S2, S4), maintains the per-slot operator-output history, and forms the registered phase-modulation input for the next operator from caller-selected history taps. It also provides a clean halt/resume handshake at frame boundaries so register updates can be applied between frames.

## Interface
Parameters:
- `W`, 14: signed operator output width.
- `NSLOT`, 24: slots per frame. Must be 24; other values are unsupported.

Ports:
- `clk`  in  1: system clock.
- `rst_n`  in  1: reset, synchronous and active-low.
- `cen`  in  1: clock enable. All state advances only when it is high.
- `op_in`  in  W: signed result of the slot just computed (slot `slot`−1).
- `xsel`  in  4: one-hot or zero tap select for the x operand: bit0 = d6, bit1 = d12, bit2 = d18, bit3 = d24.
- `ysel`  in  4: the same tap select, for the y operand.
- `halt_req`  in  1: request to stop the sequencer at the frame boundary.
- `halted`  out  1: sequencer is parked at slot 0.
- `slot`  out  5: current slot, 0..23.
- `ch`  out  3: channel of the current slot, 0..5.
- `s1_enters`, `s2_enters`, `s3_enters`, `s4_enters`  out  1 each: one-hot operator flags for the current slot.
- `zero`  out  1: high while `slot`==0 and the sequencer is running.
- `mod_out`  out  W+1: signed x+y modulation for the current slot.

## Operation
- Slot decode:
  - `ch` = `slot` mod 6.
  - Operator group = `slot`/6, mapped 0→S1, 1→S3, 2→S2, 3→S4.
  - Exactly one `sN_enters` is high while running. All four are low while halted.
- Slot counter:
  - On `cen` while running, `slot` increments.
  - 23 wraps to 0.
- History:
  - 24-entry shift register of W-bit words, `hist[1..24]`.
  - On `cen` while running: shift, then `hist[1]` ← `op_in`.
  - Tap dN = `hist[N]`, i.e. the output of the slot N positions earlier.
  - Relative to the S4 of channel c: d6 = S2, d12 = S3, d18 = S1, d24 = S4 of the previous frame.
- Modulation:
  - x = OR of the selected taps ANDed with `xsel`. y is formed the same way from `ysel`.
  - An all-zero select gives 0.
  - A select with more than one bit set is illegal; the output is undefined but must not hang.
  - `mod_out` = sext(x) + sext(y), W+1 bits, no saturation or truncation.
  - Registered on `cen`.
- Halt FSM, states RUN and PARK:
  - RUN → PARK: `halt_req`==1 on the `cen` where `slot`==23. `slot` then wraps to 0 and the sequencer parks.
  - In PARK: `halted`=1, `slot` holds at 0, history frozen, `zero`=0.
  - PARK → RUN: on the first `cen` with `halt_req`==0. `slot` stays 0 for that cycle, and the next `cen` advances to 1.
  - `halt_req` deasserted before slot 23 cancels the request; no park occurs.
- Reset (`rst_n`==0 at a `clk` edge, regardless of `cen`):
  - `slot`=0, state RUN, `halted`=0, all `hist` entries 0, `mod_out`=0.
  - Reset mid-frame discards the partial frame.

## Timing
- All outputs are registered, or decoded from registered `slot`/state only.
- Reset values:
  - `slot`=0, `ch`=0, `s1_enters`=1, other `sN_enters`=0.
  - `zero`=1, `halted`=0, `mod_out`=0.
- `mod_out` for slot k is valid in the cycle where `slot`==k.
  - It is computed on the `cen` that advanced `slot` to k, using `xsel`/`ysel` and the taps presented during slot k−1.
  - The caller drives selects one slot ahead, from the next slot's decode.
- With `cen` low, nothing changes, including the `halt_req` sampling.
- `halted` rises in the cycle `slot` returns to 0 and falls one `cen` after `halt_req` drops.
- Simultaneous `halt_req` rise and slot 23 on the same `cen` parks the sequencer immediately.

## Structure
- Shared package `jt12_pkg`:
  - `NSLOT`=24 and slot-group constants `GRP_S1`=0, `GRP_S3`=1, `GRP_S2`=2, `GRP_S4`=3.
  - Tap index constants `TAP_D6`, `TAP_D12`, `TAP_D18`, `TAP_D24`.
  - FSM state enum {RUN, PARK}.
- One sub-module, `jt12_slot_hist`:
  - Parameterised W-bit, 24-deep shift register with shift-enable and synchronous clear.
  - Exposes the four taps.
- The top level holds the counter, FSM, decode and adder.

## Test plan
- Reset then 48 `cen` cycles:
  - `slot` runs 0..23 twice.
  - `ch` sequence 0..5 repeats.
  - `s1`/`s3`/`s2`/`s4_enters` each high for 6 consecutive slots, in that order.
  - `zero` pulses at slots 0 and 24.
- Drive `op_in`=slot+100 for one frame with `xsel`=0001, `ysel`=0.
  - In frame 2 at slot 10, `mod_out` = value written 6 slots earlier.
  - Repeat with d12, d18 and d24, checking each against its offset.
- Signed add extremes:
  - x=d6=−8192 and y=d12=−8192 gives `mod_out`=−16384.
  - x=y=8191 gives `mod_out`=16382.
- Halt handshake:
  - Assert `halt_req` at slot 15: parks after slot 23, `halted`=1, `slot`=0 and all enters low for 10 cycles.
  - History unchanged while parked.
  - Release `halt_req`: slot 1 appears two `cen` later.
- Halt cancel: assert `halt_req` at slot 5, drop at slot 20. No park occurs and the counter is continuous.
- `cen` gating and reset:
  - Toggle `cen` at 1/3 duty: state advances only on enabled cycles.
  - Drop `rst_n` at slot 13 with `cen` low: next cycle `slot`=0, history zero, `mod_out`=0.

Source files
------------

// File: rtl/jt12_pkg.sv
// Shared constants and types for the jt12 operator-slot scheduler.
//   NSLOT            : slots per frame (6 channels x 4 operators)
//   GRP_S1..GRP_S4   : operator group code for slot/6 (time order S1,S3,S2,S4)
//   TAP_D6..TAP_D24  : history depths of the four modulation taps
//   sched_state_t    : halt FSM state
package jt12_pkg;

    localparam int NSLOT = 24;

    localparam logic [1:0] GRP_S1 = 2'd0;
    localparam logic [1:0] GRP_S3 = 2'd1;
    localparam logic [1:0] GRP_S2 = 2'd2;
    localparam logic [1:0] GRP_S4 = 2'd3;

    localparam int TAP_D6  = 6;
    localparam int TAP_D12 = 12;
    localparam int TAP_D18 = 18;
    localparam int TAP_D24 = 24;

    typedef enum logic {
        RUN  = 1'b0,
        PARK = 1'b1
    } sched_state_t;

endpackage

// File: rtl/jt12_slot_hist.sv
// 24-deep history of operator outputs, hist[1] newest.
// Ports:
//   clk      in  : system clock
//   clr      in  : synchronous clear of every entry
//   shift_en in  : shift one position and load din into hist[1]
//   din      in  : W-bit signed operator output
//   d6..d24  out : taps hist[6], hist[12], hist[18], hist[24]
module jt12_slot_hist #(
    parameter int W = 14
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                shift_en,
    input  logic signed [W-1:0] din,
    output logic signed [W-1:0] d6,
    output logic signed [W-1:0] d12,
    output logic signed [W-1:0] d18,
    output logic signed [W-1:0] d24
);
    import jt12_pkg::*;

    logic signed [W-1:0] hist [1:NSLOT];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 1; i <= NSLOT; i++) hist[i] <= '0;
        end else if (shift_en) begin
            hist[1] <= din;
            for (int i = 2; i <= NSLOT; i++) hist[i] <= hist[i-1];
        end
    end

    assign d6  = hist[TAP_D6];
    assign d12 = hist[TAP_D12];
    assign d18 = hist[TAP_D18];
    assign d24 = hist[TAP_D24];

endmodule

// File: rtl/jt12_slot_sched.sv
// Operator-slot scheduler: slot counter, slot decode, operator history and
// registered x+y phase-modulation input, with a frame-boundary halt handshake.
//
// state | meaning
// RUN   | slot advances every cen, history shifts
// PARK  | parked at slot 0, history frozen, all sN_enters low
//
// Ports:
//   clk, rst_n (sync, active-low), cen (clock enable)
//   op_in     : signed result of slot-1
//   xsel/ysel : one-hot tap selects {d24,d18,d12,d6}, zero gives 0
//   halt_req  : park at the next frame boundary while high
//   halted, slot, ch, s1..s4_enters, zero : registered / decoded status
//   mod_out   : registered signed x+y for the current slot (W+1 bits)
module jt12_slot_sched #(
    parameter int W     = 14,
    parameter int NSLOT = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cen,
    input  logic signed [W-1:0] op_in,
    input  logic [3:0]        xsel,
    input  logic [3:0]        ysel,
    input  logic              halt_req,
    output logic              halted,
    output logic [4:0]        slot,
    output logic [2:0]        ch,
    output logic              s1_enters,
    output logic              s2_enters,
    output logic              s3_enters,
    output logic              s4_enters,
    output logic              zero,
    output logic signed [W:0] mod_out
);
    import jt12_pkg::*;

    localparam logic [4:0] LAST_SLOT = 5'(NSLOT - 1);

    sched_state_t        state;
    logic                running;
    logic [1:0]          grp;
    logic [4:0]          grp_base;
    logic [4:0]          ch_full;
    logic signed [W-1:0] d6, d12, d18, d24;
    logic signed [W-1:0] x, y;

    jt12_slot_hist #(.W(W)) u_hist (
        .clk      (clk),
        .clr      (~rst_n),
        .shift_en (cen & running),
        .din      (op_in),
        .d6       (d6),
        .d12      (d12),
        .d18      (d18),
        .d24      (d24)
    );

    assign running = (state == RUN);

    // slot/6 and slot mod 6 without a divider
    always_comb begin
        grp      = GRP_S4;
        grp_base = 5'd18;
        if (slot < 5'd6) begin
            grp      = GRP_S1;
            grp_base = 5'd0;
        end else if (slot < 5'd12) begin
            grp      = GRP_S3;
            grp_base = 5'd6;
        end else if (slot < 5'd18) begin
            grp      = GRP_S2;
            grp_base = 5'd12;
        end
        ch_full = slot - grp_base;
    end

    assign ch        = ch_full[2:0];
    assign s1_enters = running && (grp == GRP_S1);
    assign s3_enters = running && (grp == GRP_S3);
    assign s2_enters = running && (grp == GRP_S2);
    assign s4_enters = running && (grp == GRP_S4);
    assign zero      = running && (slot == 5'd0);
    assign halted    = (state == PARK);

    // AND-OR tap mux; multi-hot selects just OR the taps together
    assign x = ({W{xsel[0]}} & d6) | ({W{xsel[1]}} & d12) |
               ({W{xsel[2]}} & d18) | ({W{xsel[3]}} & d24);
    assign y = ({W{ysel[0]}} & d6) | ({W{ysel[1]}} & d12) |
               ({W{ysel[2]}} & d18) | ({W{ysel[3]}} & d24);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= RUN;
            slot    <= 5'd0;
            mod_out <= '0;
        end else if (cen) begin
            mod_out <= {x[W-1], x} + {y[W-1], y};
            case (state)
                RUN: begin
                    if (slot == LAST_SLOT) begin
                        slot <= 5'd0;
                        if (halt_req) state <= PARK;
                    end else begin
                        slot <= slot + 5'd1;
                    end
                end
                PARK: begin
                    // slot stays 0 on the resume cycle; next cen advances it
                    if (!halt_req) state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_jt12_slot_sched.sv
module tb_jt12_slot_sched;

    localparam int W = 14;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                cen;
    logic signed [W-1:0] op_in;
    logic [3:0]          xsel;
    logic [3:0]          ysel;
    logic                halt_req;
    logic                halted;
    logic [4:0]          slot;
    logic [2:0]          ch;
    logic                s1_enters, s2_enters, s3_enters, s4_enters;
    logic                zero;
    logic signed [W:0]   mod_out;

    int nchk  = 0;
    int nfail = 0;
    int ts    = 0;

    jt12_slot_sched #(.W(W), .NSLOT(24)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cen       (cen),
        .op_in     (op_in),
        .xsel      (xsel),
        .ysel      (ysel),
        .halt_req  (halt_req),
        .halted    (halted),
        .slot      (slot),
        .ch        (ch),
        .s1_enters (s1_enters),
        .s2_enters (s2_enters),
        .s3_enters (s3_enters),
        .s4_enters (s4_enters),
        .zero      (zero),
        .mod_out   (mod_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one enabled running cycle with op_in = slot+100
    task automatic run1();
        op_in = W'(ts + 100);
        cen   = 1'b1;
        tick();
        ts = (ts + 1) % 24;
        chk("slot_run", slot, ts);
    endtask

    // {s4,s3,s2,s1}: groups in time order S1, S3, S2, S4
    function automatic logic [3:0] exp_en(input int s);
        case (s / 6)
            0:       return 4'b0001;
            1:       return 4'b0100;
            2:       return 4'b0010;
            default: return 4'b1000;
        endcase
    endfunction

    task automatic check_decode(input int s);
        chk("dec_slot", slot, s);
        chk("dec_ch", ch, s % 6);
        chk("dec_enters", {s4_enters, s3_enters, s2_enters, s1_enters}, exp_en(s));
        chk("dec_zero", zero, (s == 0) ? 1 : 0);
        chk("dec_halted", halted, 0);
    endtask

    task automatic frame_sel(input logic [3:0] xs, input logic [3:0] ys,
                             input string tag, input int exp);
        for (int s = 0; s < 24; s++) begin
            xsel = xs;
            ysel = ys;
            run1();
            if (s == 9) chk(tag, mod_out, exp);
        end
    endtask

    task automatic frame_const(input int val, input logic [3:0] xs,
                               input logic [3:0] ys, input string tag, input int exp);
        for (int s = 0; s < 24; s++) begin
            op_in = W'(val);
            xsel  = xs;
            ysel  = ys;
            cen   = 1'b1;
            tick();
            ts = (ts + 1) % 24;
        end
        chk(tag, mod_out, exp);
    endtask

    initial begin
        rst_n = 1'b0; cen = 1'b0; op_in = '0; xsel = '0; ysel = '0; halt_req = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // reset state
        chk("rst_slot", slot, 0);
        chk("rst_ch", ch, 0);
        chk("rst_enters", {s4_enters, s3_enters, s2_enters, s1_enters}, 4'b0001);
        chk("rst_zero", zero, 1);
        chk("rst_halted", halted, 0);
        chk("rst_mod", mod_out, 0);

        // two frames of decode; d6 tap at frame-2 slot 10 = value from slot 3
        ts = 0;
        for (int i = 0; i < 48; i++) begin
            check_decode(ts);
            if (i == 34) chk("mod_d6", mod_out, 103);
            xsel = 4'b0001;
            ysel = 4'b0000;
            run1();
        end

        // remaining taps at slot 10: taps seen at slot 9 are slot (9-N) mod 24
        frame_sel(4'b0010, 4'b0000, "mod_d12", 121);
        frame_sel(4'b0100, 4'b0000, "mod_d18", 115);
        frame_sel(4'b1000, 4'b0000, "mod_d24", 109);
        frame_sel(4'b0001, 4'b0010, "mod_d6_d12", 224);
        frame_sel(4'b0000, 4'b0000, "mod_nosel", 0);

        // signed extremes
        frame_const(-8192, 4'b0001, 4'b0010, "mod_min", -16384);
        frame_const(8191, 4'b0001, 4'b0001, "mod_max", 16382);
        frame_const(8191, 4'b0001, 4'b0000, "mod_x_only", 8191);

        // halt requested from slot 15, parks after slot 23
        ts = 0;
        for (int s = 0; s < 24; s++) begin
            halt_req = (s >= 15);
            xsel = 4'b0001;
            ysel = 4'b0000;
            run1();
            if (s == 22) chk("halt_not_early", halted, 0);
        end
        chk("park_halted", halted, 1);
        chk("park_zero", zero, 0);
        chk("park_enters", {s4_enters, s3_enters, s2_enters, s1_enters}, 0);
        for (int j = 0; j < 10; j++) begin
            op_in = W'(999);
            halt_req = 1'b1;
            cen = 1'b1;
            tick();
            chk("park_slot", slot, 0);
            chk("park_hold", halted, 1);
            chk("park_enters_hold", {s4_enters, s3_enters, s2_enters, s1_enters}, 0);
            // hist[6] frozen at the value written at slot 18
            chk("park_hist", mod_out, 118);
        end
        halt_req = 1'b0;
        cen = 1'b1;
        tick();
        chk("resume_slot0", slot, 0);
        chk("resume_halted", halted, 0);
        chk("resume_zero", zero, 1);
        chk("resume_s1", s1_enters, 1);
        run1();

        // cancelled halt: request from slot 5 to slot 20
        while (ts != 5) run1();
        halt_req = 1'b1;
        while (ts != 20) run1();
        halt_req = 1'b0;
        while (ts != 23) run1();
        run1();
        chk("cancel_halted", halted, 0);
        chk("cancel_zero", zero, 1);
        run1();
        chk("cancel_run", halted, 0);

        // cen at 1/3 duty
        for (int j = 0; j < 12; j++) begin
            cen = (j % 3 == 0);
            op_in = W'(500);
            tick();
            if (j % 3 == 0) ts = (ts + 1) % 24;
            chk("cen_slot", slot, ts);
        end

        // reset at slot 13 with cen low
        xsel = 4'b0001;
        ysel = 4'b0000;
        while (ts != 13) run1();
        cen = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ts = 0;
        chk("rst2_slot", slot, 0);
        chk("rst2_mod", mod_out, 0);
        chk("rst2_zero", zero, 1);
        chk("rst2_s1", s1_enters, 1);
        xsel = 4'b1000;
        ysel = 4'b0001;
        run1();
        chk("rst2_hist", mod_out, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
